outport_fifo: RTL and testbench
===============================

// Module: outport_fifo
// PURPOSE
//   Buffered output port between the PicoBlaze I/O bus and an external byte-stream peripheral.
//   Core writes to address ADDR are pushed into a DEPTH-entry FIFO.
//   The FIFO drains to the device through a valid/ready handshake.
//   A status byte at STAT_ADDR feeds the input-port selector, so firmware can poll fill level and overflow.
// PARAMETERS
//   ADDR        8'h05  port address accepted for data writes
//   STAT_ADDR   8'h06  port address of the status byte
//   DEPTH       4      FIFO entries; power of two, 2..8
//   AW          2      log2(DEPTH); pointer width
// PORTS
//   clk        in   1  system clock; all state updates on rising edge
//   rst        in   1  reset, asynchronous, active-low (0 = reset)
//   address    in   8  core port address
//   value_in   in   8  core write data
//   wen        in   1  core write strobe (may be held >1 cycle)
//   ren        in   1  core read strobe (may be held >1 cycle)
//   stat_out   out  8  status byte; 8'h00 unless address==STAT_ADDR
//   dev_data   out  8  head-of-FIFO byte to peripheral
//   dev_valid  out  1  dev_data is valid
//   dev_ready  in   1  peripheral accepts dev_data this cycle
// BEHAVIOUR
//   Reset (rst=0, async):
//     - wr_ptr, rd_ptr, count = 0; ovf = 0; wen_d, ren_d = 0.
//     - Outputs: dev_valid=0, dev_data=8'h00, stat_out per address (count=0, empty=1).
//     - FIFO storage is not reset.
//     - Reset mid-transfer discards all queued bytes immediately; no handshake completes.
//   Strobe edge detect: wen_d/ren_d are wen/ren registered each clk.
//     - wr_ev = wen & ~wen_d & (address==ADDR); exactly one event per strobe regardless of length.
//     - rd_ev = ren & ~ren_d & (address==STAT_ADDR).
//   Push: on wr_ev, if not full (or a pop occurs the same cycle):
//     - mem[wr_ptr] <= value_in; wr_ptr++ (wraps DEPTH-1 -> 0).
//   Drop: on wr_ev while full with no pop that cycle:
//     - byte discarded, ovf <= 1 (sticky); pointers and count unchanged.
//   Pop: when dev_valid & dev_ready at a clk edge, rd_ptr++ (wraps).
//   Count: +1 on push only, -1 on pop only, unchanged on push+pop or neither.
//     - Range 0..DEPTH; never over/underflows.
//   Outputs:
//     - dev_valid = (count != 0).
//     - dev_data = mem[rd_ptr] when dev_valid, else 8'h00.
//     - Combinational from registers; dev_data is stable while dev_valid & ~dev_ready.
//   Latency: wr_ev in cycle N into an empty FIFO -> dev_valid=1 in cycle N+1. No bypass path.
//   Simultaneous events:
//     - Empty + push: no pop (valid=0); count -> 1.
//     - Full + push + pop: both accepted; count stays DEPTH; no ovf.
//   stat_out (address==STAT_ADDR): {ovf, full, empty, 1'b0, count[3:0]}.
//     - full = (count==DEPTH), empty = (count==0); count zero-extended.
//   ovf clear: on rd_ev, ovf <= 0.
//     - If a drop occurs in the same cycle, set wins (ovf stays 1).
//     - The read that returns ovf=1 sees it before the clear (combinational status).
// TESTING
//   1. rst=0 then 1 -> dev_valid=0, dev_data=8'h00; address=06 gives stat_out=8'h20.
//   2. address=05, value_in=AA, wen held high 3 cycles, dev_ready=0:
//      -> exactly one push; dev_valid next cycle; dev_data=AA; stat_out=8'h01.
//   3. Write 11,22,33,44,55 with dev_ready=0:
//      -> stat_out=8'hC4 (55 dropped); dev_ready=1 -> 11,22,33,44 over 4 cycles, then dev_valid=0.
//   4. FIFO full, dev_ready=1, write 66 in the same cycle as a pop:
//      -> no ovf; count stays 4; 66 emerges last.
//   5. ovf=1, ren pulse at address 06 -> that read shows bit7=1; next read shows bit7=0.
//      Same-cycle drop + clear -> bit7 stays 1.
//   6. Assert rst mid-drain with 3 bytes queued -> dev_valid=0 immediately; after release stat_out=8'h20.

Source files
------------

// File: rtl/outport_fifo.sv
// Buffered PicoBlaze output port: edge-detected core writes feed a small FIFO that
// drains to a byte-stream peripheral; a status byte reports fill level and overflow.
module outport_fifo #(
    parameter logic [7:0] ADDR      = 8'h05,
    parameter logic [7:0] STAT_ADDR = 8'h06,
    parameter int         DEPTH     = 4,
    parameter int         AW        = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] address,
    input  logic [7:0] value_in,
    input  logic       wen,
    input  logic       ren,
    output logic [7:0] stat_out,
    output logic [7:0] dev_data,
    output logic       dev_valid,
    input  logic       dev_ready
);

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          wen_q, ren_q;

    logic wr_ev, rd_ev, pop, push, drop, full, empty;

    // Handshake: a byte transfers on every rising edge where dev_valid & dev_ready are
    // both high; dev_data holds steady while dev_valid is high and dev_ready is low.
    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign dev_valid = ~empty;
    assign dev_data  = dev_valid ? mem[rd_ptr_q] : 8'h00;
    assign stat_out  = (address == STAT_ADDR) ? {ovf_q, full, empty, 1'b0, 4'(count_q)} : 8'h00;

    assign wr_ev = wen & ~wen_q & (address == ADDR);
    assign rd_ev = ren & ~ren_q & (address == STAT_ADDR);
    assign pop   = dev_valid & dev_ready;
    // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
    assign push  = wr_ev & (~full | pop);
    assign drop  = wr_ev & full & ~pop;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)
            count_d = count_q + CNT_ONE;
        else if (pop && !push)
            count_d = count_q - CNT_ONE;
        ovf_d = ovf_q;
        if (drop)
            ovf_d = 1'b1;
        else if (rd_ev)
            ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            wen_q    <= 1'b0;
            ren_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            wen_q    <= wen;
            ren_q    <= ren;
        end
    end

    // Storage is deliberately left out of reset; count gates what is visible.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_q] <= value_in;
    end

endmodule

// File: tb/tb_outport_fifo.sv
// Directed bench for outport_fifo: reset, strobe edge detect, overflow, full push+pop,
// status clear and reset mid-drain, with hand-computed expected bytes.
module tb_outport_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] address = 8'h00;
    logic [7:0] value_in = 8'h00;
    logic       wen = 1'b0;
    logic       ren = 1'b0;
    logic       dev_ready = 1'b0;
    logic [7:0] stat_out, dev_data;
    logic       dev_valid;

    // Second instance with data and status on one address, so a drop and a status
    // read can land in the same cycle.
    logic [7:0] b_address = 8'h06;
    logic [7:0] b_value = 8'h00;
    logic       b_wen = 1'b0;
    logic       b_ren = 1'b0;
    logic       b_dev_ready = 1'b0;
    logic [7:0] b_stat, b_data;
    logic       b_valid;

    int error_count = 0;
    int check_count = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    outport_fifo dut (
        .clk(clk), .rst(rst), .address(address), .value_in(value_in),
        .wen(wen), .ren(ren), .stat_out(stat_out), .dev_data(dev_data),
        .dev_valid(dev_valid), .dev_ready(dev_ready)
    );

    outport_fifo #(.ADDR(8'h06), .STAT_ADDR(8'h06)) dut_b (
        .clk(clk), .rst(rst), .address(b_address), .value_in(b_value),
        .wen(b_wen), .ren(b_ren), .stat_out(b_stat), .dev_data(b_data),
        .dev_valid(b_valid), .dev_ready(b_dev_ready)
    );

    task automatic write_byte(input logic [7:0] b);
        @(negedge clk);
        address = 8'h05; value_in = b; wen = 1'b1;
        @(negedge clk);
        wen = 1'b0;
    endtask

    task automatic check_stat(input string name, input logic [7:0] exp);
        address = 8'h06;
        #1;
        check_count++;
        if (stat_out !== exp) begin
            error_count++;
            $display("FAIL %s: stat_out=%h expected=%h", name, stat_out, exp);
        end
    endtask

    task automatic check_valid(input string name, input logic exp);
        #1;
        check_count++;
        if (dev_valid !== exp) begin
            error_count++;
            $display("FAIL %s: dev_valid=%b expected=%b", name, dev_valid, exp);
        end
    endtask

    // Drains exp_q with dev_ready high, one byte per cycle, then expects empty.
    task automatic drain_and_check(input string name);
        @(negedge clk);
        dev_ready = 1'b1;
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            #1;
            check_count++;
            if (dev_valid !== 1'b1 || dev_data !== e) begin
                error_count++;
                $display("FAIL %s: valid=%b data=%h expected valid=1 data=%h", name, dev_valid, dev_data, e);
            end
            @(negedge clk);
        end
        check_valid({name, "_empty"}, 1'b0);
        check_count++;
        if (dev_data !== 8'h00) begin
            error_count++;
            $display("FAIL %s_data0: dev_data=%h expected=00", name, dev_data);
        end
        dev_ready = 1'b0;
    endtask

    task automatic test_reset();
        address = 8'h06;
        #3;
        check_valid("reset_valid", 1'b0);
        check_count++;
        if (dev_data !== 8'h00) begin
            error_count++;
            $display("FAIL reset_data: dev_data=%h expected=00", dev_data);
        end
        check_stat("reset_stat", 8'h20);
        @(negedge clk);
        rst = 1'b1;
        check_stat("post_reset_stat", 8'h20);
        address = 8'h00;
        #1;
        check_count++;
        if (stat_out !== 8'h00) begin
            error_count++;
            $display("FAIL stat_other_addr: stat_out=%h expected=00", stat_out);
        end
    endtask

    task automatic test_wen_hold();
        @(negedge clk);
        address = 8'h05; value_in = 8'hAA; wen = 1'b1;
        check_valid("no_bypass", 1'b0);
        @(negedge clk);
        check_valid("latency_one", 1'b1);
        @(negedge clk);
        @(negedge clk);
        wen = 1'b0;
        check_stat("hold_one_push", 8'h01);
        exp_q.push_back(8'hAA);
        drain_and_check("hold_drain");
    endtask

    task automatic test_overflow();
        write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
        write_byte(8'h44); write_byte(8'h55);
        check_stat("ovf_stat", 8'hC4);
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        drain_and_check("ovf_drain");
        check_stat("ovf_sticky", 8'hA0);
    endtask

    task automatic test_ovf_clear();
        @(negedge clk);
        ren = 1'b1;
        check_stat("clear_read_sees_ovf", 8'hA0);
        @(negedge clk);
        ren = 1'b0;
        check_stat("after_clear", 8'h20);
        @(negedge clk);
        ren = 1'b1;
        check_stat("second_read", 8'h20);
        @(negedge clk);
        ren = 1'b0;
    endtask

    task automatic test_full_push_pop();
        write_byte(8'hA1); write_byte(8'hA2); write_byte(8'hA3); write_byte(8'hA4);
        check_stat("full_stat", 8'h44);
        @(negedge clk);
        dev_ready = 1'b1; address = 8'h05; value_in = 8'h66; wen = 1'b1;
        #1;
        check_count++;
        if (dev_data !== 8'hA1) begin
            error_count++;
            $display("FAIL pushpop_head: dev_data=%h expected=a1", dev_data);
        end
        @(negedge clk);
        wen = 1'b0; dev_ready = 1'b0;
        check_stat("pushpop_stat", 8'h44);
        exp_q = '{8'hA2, 8'hA3, 8'hA4, 8'h66};
        drain_and_check("pushpop_drain");
    endtask

    task automatic test_drop_and_clear_same_cycle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b_value = 8'(8'h30 + i); b_wen = 1'b1;
            @(negedge clk);
            b_wen = 1'b0;
        end
        @(negedge clk);
        b_value = 8'h77; b_wen = 1'b1; b_ren = 1'b1;
        #1;
        check_count++;
        if (b_stat !== 8'h44) begin
            error_count++;
            $display("FAIL b_before_drop: stat_out=%h expected=44", b_stat);
        end
        @(negedge clk);
        b_wen = 1'b0; b_ren = 1'b0;
        #1;
        check_count++;
        if (b_stat !== 8'hC4) begin
            error_count++;
            $display("FAIL b_set_wins: stat_out=%h expected=c4", b_stat);
        end
        @(negedge clk);
        b_ren = 1'b1;
        @(negedge clk);
        b_ren = 1'b0;
        #1;
        check_count++;
        if (b_stat !== 8'h44) begin
            error_count++;
            $display("FAIL b_cleared: stat_out=%h expected=44", b_stat);
        end
    endtask

    task automatic test_reset_mid_drain();
        write_byte(8'hB1); write_byte(8'hB2); write_byte(8'hB3);
        check_stat("mid_stat", 8'h03);
        @(negedge clk);
        dev_ready = 1'b1;
        #2;
        rst = 1'b0;
        check_valid("mid_reset_valid", 1'b0);
        check_stat("mid_reset_stat", 8'h20);
        @(negedge clk);
        rst = 1'b1;
        dev_ready = 1'b0;
        @(negedge clk);
        check_stat("after_release_stat", 8'h20);
        check_valid("after_release_valid", 1'b0);
    endtask

    initial begin
        test_reset();
        test_wen_hold();
        test_overflow();
        test_ovf_clear();
        test_full_push_pop();
        test_drop_and_clear_same_cycle();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
